division_con_signo_secuencial: RTL and testbench

DIVISION_CON_SIGNO_SECUENCIAL -- requirements
Module: division_con_signo_secuencial

---
 rtl/division_con_signo_secuencial.sv | 220 ++++++++++++++++++++++
 tb/tb_division_con_signo_secuencial.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/division_con_signo_secuencial.sv
// -----------------------------------------------------------------------------
// division_con_signo_secuencial
//
// Sequential signed fixed-point divider. It computes
//     q = ((a - c) * 2^FRAC) / b
// The result is truncated toward zero and then saturated to ANCHO bits.
// This is the inverse of the multiply-add datapath (q*b + c = a).
// The core is a restoring divider that produces one quotient bit per cycle.
// It works on magnitudes; the sign is applied at the end.
//
// Parameters
//   ANCHO  word width of every operand and of the result (two's complement)
//   FRAC   fractional bits; the operands use the format Q(ANCHO-FRAC).FRAC
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   inicio              start request; sampled only in IDLE
//   operando1           dividend term a (signed)
//   operando2           divisor b (signed)
//   operando3           offset c (signed)
//   resultado_division  result q (signed); updated only in FIX
//   ocupado             high in PREP, DIV and FIX
//   listo               one-cycle completion pulse (FIN)
//   desborde            the result was saturated
//   div_cero            operando2 was zero
// -----------------------------------------------------------------------------
module division_con_signo_secuencial #(
    parameter int ANCHO = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [ANCHO-1:0] operando1,
    input  logic [ANCHO-1:0] operando2,
    input  logic [ANCHO-1:0] operando3,
    output logic [ANCHO-1:0] resultado_division,
    output logic             ocupado,
    output logic             listo,
    output logic             desborde,
    output logic             div_cero
);

    // Quotient bits. |a - c| needs ANCHO+1 bits, and the pre-scale adds FRAC.
    localparam int NB = ANCHO + 1 + FRAC;
    localparam int CW = $clog2(NB + 1);

    localparam logic [ANCHO-1:0] MAX_POS = {1'b0, {(ANCHO-1){1'b1}}};
    localparam logic [ANCHO-1:0] MIN_NEG = {1'b1, {(ANCHO-1){1'b0}}};
    // These are the largest magnitudes that fit, per sign of the result.
    localparam logic [NB-1:0]    LIM_POS = NB'(MAX_POS);
    localparam logic [NB-1:0]    LIM_NEG = NB'(MIN_NEG);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        FIN
    } t_estado;

    t_estado r_estado;
    t_estado w_estado_next;

    // Captured operands
    logic [ANCHO-1:0] r_a;
    logic [ANCHO-1:0] r_b;
    logic [ANCHO-1:0] r_c;

    // Divider state
    logic [ANCHO:0]   r_divisor;    // |b|
    logic [ANCHO:0]   r_resto;      // partial remainder, always < |b|
    logic [NB-1:0]    r_cociente;   // dividend shifts out MSB-first, quotient shifts in
    logic [CW-1:0]    r_cnt;
    logic             r_signo;      // sign of the final quotient
    logic             r_d_neg;      // (a - c) < 0, selects the divide-by-zero result

    // Output registers
    logic [ANCHO-1:0] r_resultado;
    logic             r_desborde;
    logic             r_div_cero;

    // Combinational helpers
    logic [ANCHO:0]   w_d;
    logic [ANCHO:0]   w_abs_d;
    logic [ANCHO:0]   w_b_ext;
    logic [ANCHO:0]   w_abs_b;
    logic             w_b_cero;
    logic [ANCHO+1:0] w_prueba;
    logic             w_cabe;
    logic [ANCHO:0]   w_resta;
    logic [ANCHO-1:0] w_neg_coc;
    logic [ANCHO-1:0] w_fix_res;
    logic             w_fix_ovf;

    // a - c is formed one bit wider, so the difference can never wrap.
    assign w_d      = {r_a[ANCHO-1], r_a} - {r_c[ANCHO-1], r_c};
    assign w_abs_d  = w_d[ANCHO] ? -w_d : w_d;
    assign w_b_ext  = {r_b[ANCHO-1], r_b};
    assign w_abs_b  = w_b_ext[ANCHO] ? -w_b_ext : w_b_ext;
    assign w_b_cero = (r_b == '0);

    // One restoring step: bring down the next dividend bit and try to subtract |b|.
    // The remainder stays below |b|, so the difference fits in ANCHO+1 bits.
    assign w_prueba = {r_resto, r_cociente[NB-1]};
    assign w_cabe   = (w_prueba >= {1'b0, r_divisor});
    assign w_resta  = w_prueba[ANCHO:0] - r_divisor;

    // Only the low bits of the negated quotient matter.
    // Larger magnitudes are saturated instead.
    assign w_neg_coc = -r_cociente[ANCHO-1:0];

    // Sign application and saturation. A zero magnitude negates to zero,
    // so there is no negative zero.
    always_comb begin
        w_fix_res = r_cociente[ANCHO-1:0];
        w_fix_ovf = 1'b0;
        if (w_b_cero) begin
            w_fix_res = r_d_neg ? MIN_NEG : MAX_POS;
        end else if (r_signo) begin
            if (r_cociente > LIM_NEG) begin
                w_fix_res = MIN_NEG;
                w_fix_ovf = 1'b1;
            end else begin
                w_fix_res = w_neg_coc;
            end
        end else if (r_cociente > LIM_POS) begin
            w_fix_res = MAX_POS;
            w_fix_ovf = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            IDLE: if (inicio) w_estado_next = PREP;
            PREP: w_estado_next = w_b_cero ? FIX : DIV;
            DIV:  if (r_cnt == '0) w_estado_next = FIX;
            FIX:  w_estado_next = FIN;
            FIN:  w_estado_next = IDLE;
            default: w_estado_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_divisor   <= '0;
            r_resto     <= '0;
            r_cociente  <= '0;
            r_cnt       <= '0;
            r_signo     <= 1'b0;
            r_d_neg     <= 1'b0;
            r_resultado <= '0;
            r_desborde  <= 1'b0;
            r_div_cero  <= 1'b0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (inicio) begin
                        r_a <= operando1;
                        r_b <= operando2;
                        r_c <= operando3;
                    end
                end
                PREP: begin
                    r_signo    <= w_d[ANCHO] ^ r_b[ANCHO-1];
                    r_d_neg    <= w_d[ANCHO];
                    r_cociente <= NB'(w_abs_d) << FRAC;
                    r_resto    <= '0;
                    r_divisor  <= w_abs_b;
                    // Count down NB-1..0, which gives exactly NB DIV cycles.
                    r_cnt      <= CW'(NB - 1);
                end
                DIV: begin
                    if (w_cabe) begin
                        r_resto    <= w_resta;
                        r_cociente <= {r_cociente[NB-2:0], 1'b1};
                    end else begin
                        r_resto    <= w_prueba[ANCHO:0];
                        r_cociente <= {r_cociente[NB-2:0], 1'b0};
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    r_resultado <= w_fix_res;
                    r_desborde  <= w_fix_ovf;
                    r_div_cero  <= w_b_cero;
                end
                default: begin
                end
            endcase
        end
    end

    // These flags are decoded from the state register, which has an
    // asynchronous reset. Reset therefore clears them at once.
    assign ocupado            = (r_estado == PREP) || (r_estado == DIV) || (r_estado == FIX);
    assign listo              = (r_estado == FIN);
    assign resultado_division = r_resultado;
    assign desborde           = r_desborde;
    assign div_cero           = r_div_cero;

endmodule

// File: tb/tb_division_con_signo_secuencial.sv
module tb_division_con_signo_secuencial;

    localparam int ANCHO      = 16;
    localparam int FRAC       = 8;
    localparam int N          = ANCHO + 1 + FRAC;
    // Edges counted from the accepting edge (inclusive) until listo is high.
    localparam int LAT_NORMAL = N + 3;
    localparam int LAT_CERO   = 3;
    localparam longint ESCALA = 256;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [15:0] operando1;
    logic [15:0] operando2;
    logic [15:0] operando3;
    logic [15:0] resultado_division;
    logic        ocupado;
    logic        listo;
    logic        desborde;
    logic        div_cero;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    division_con_signo_secuencial #(.ANCHO(ANCHO), .FRAC(FRAC)) dut (
        .clk                (clk),
        .reset              (reset),
        .inicio             (inicio),
        .operando1          (operando1),
        .operando2          (operando2),
        .operando3          (operando3),
        .resultado_division (resultado_division),
        .ocupado            (ocupado),
        .listo              (listo),
        .desborde           (desborde),
        .div_cero           (div_cero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                input logic [15:0] q, input logic ovf, input logic dz);
        vec_t v;
        v.a = a; v.b = b; v.c = c;
        v.e.q = q; v.e.ovf = ovf; v.e.dz = dz;
        return v;
    endfunction

    // Integer reference: exact division with truncation toward zero, then clamp.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        exp_t   r;
        longint da, db, dc, d, q;
        da = longint'($signed(a));
        db = longint'($signed(b));
        dc = longint'($signed(c));
        d  = da - dc;
        r.ovf = 1'b0;
        r.dz  = 1'b0;
        r.q   = 16'h0000;
        if (db == 0) begin
            r.dz = 1'b1;
            r.q  = (d >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            q = (d * ESCALA) / db;
            if (q > 32767) begin
                r.q = 16'h7FFF; r.ovf = 1'b1;
            end else if (q < -32768) begin
                r.q = 16'h8000; r.ovf = 1'b1;
            end else begin
                r.q = q[15:0];
            end
        end
        return r;
    endfunction

    // Scoreboard consumer: every listo pulse must match the oldest pending result.
    always @(posedge clk) begin
        #1;
        if (listo) begin
            chk("listo_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("resultado", 32'(resultado_division), 32'(mon_e.q));
                chk("desborde", 32'(desborde), 32'(mon_e.ovf));
                chk("div_cero", 32'(div_cero), 32'(mon_e.dz));
            end
            $display("txn: resultado=%h desborde=%b div_cero=%b", resultado_division, desborde, div_cero);
        end
    end

    // Runs one operation and checks latency and the ocupado/listo timing.
    // repulse_at >= 0 pulses inicio (with junk operands) on that edge index.
    task automatic run_op(input vec_t v, input int repulse_at);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        reset     = 1'b0;
        operando1 = v.a;
        operando2 = v.b;
        operando3 = v.c;
        inicio    = 1'b1;
        sb.push_back(v.e);
        @(posedge clk); #1;
        inicio  = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!listo && cyc < 100) begin
            if (!ocupado) busy_ok = 1'b0;
            if (cyc == repulse_at) begin
                inicio    = 1'b1;
                operando1 = ~v.a;
                operando2 = 16'h0001;
                operando3 = 16'h0000;
            end
            if (cyc == repulse_at + 1) inicio = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latencia", 32'(cyc), 32'(v.e.dz ? LAT_CERO : LAT_NORMAL));
        chk("ocupado_durante", 32'(busy_ok), 32'd1);
        chk("ocupado_en_fin", 32'(ocupado), 32'd0);
        @(posedge clk); #1;
        chk("listo_un_ciclo", 32'(listo), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tabla[14];
        vec_t v;
        int   cyc;

        tabla[0]  = mk(16'h0300, 16'h0080, 16'h0100, 16'h0400, 1'b0, 1'b0);
        tabla[1]  = mk(16'h0100, 16'h0200, 16'h0400, 16'hFE80, 1'b0, 1'b0);
        tabla[2]  = mk(16'h0001, 16'h0300, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tabla[3]  = mk(16'h7F00, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
        tabla[4]  = mk(16'h7F00, 16'hFFFF, 16'h8000, 16'h8000, 1'b1, 1'b0);
        tabla[5]  = mk(16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
        tabla[6]  = mk(16'h8000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1);
        tabla[7]  = mk(16'h0000, 16'h0100, 16'h0100, 16'hFF00, 1'b0, 1'b0);
        tabla[8]  = mk(16'h8000, 16'h0100, 16'h0000, 16'h8000, 1'b0, 1'b0);
        tabla[9]  = mk(16'h7FFF, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b0);
        tabla[10] = mk(16'h7FFF, 16'h0100, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0);
        tabla[11] = mk(16'hFFFF, 16'h0200, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tabla[12] = mk(16'h0100, 16'h0000, 16'h0100, 16'h7FFF, 1'b0, 1'b1);
        tabla[13] = mk(16'hFD00, 16'hFF00, 16'h0000, 16'h0300, 1'b0, 1'b0);

        reset     = 1'b1;
        inicio    = 1'b0;
        operando1 = '0;
        operando2 = '0;
        operando3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resultado", 32'(resultado_division), 32'd0);
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        chk("reset_listo", 32'(listo), 32'd0);
        chk("reset_desborde", 32'(desborde), 32'd0);
        chk("reset_div_cero", 32'(div_cero), 32'd0);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            run_op(tabla[i], -1);
        end

        // Random vectors checked against the integer model
        for (int i = 0; i < 10; i++) begin
            v.a = 16'($urandom());
            v.b = (i == 3) ? 16'h0000 : 16'($urandom());
            v.c = 16'($urandom());
            v.e = model(v.a, v.b, v.c);
            run_op(v, -1);
        end

        // inicio pulsed again at edge 10 must be ignored
        run_op(tabla[0], 10);
        repeat (40) @(posedge clk);
        #1;
        chk("repulse_sin_efecto", 32'(ocupado), 32'd0);
        chk("repulse_resultado_fijo", 32'(resultado_division), 32'h0400);

        // inicio held high: a new operation starts on the first edge in IDLE
        @(negedge clk);
        operando1 = tabla[1].a; operando2 = tabla[1].b; operando3 = tabla[1].c;
        inicio = 1'b1;
        sb.push_back(tabla[1].e);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!listo && cyc < 100);
        chk("held_latencia1", 32'(cyc), 32'(LAT_NORMAL));
        operando1 = tabla[3].a; operando2 = tabla[3].b; operando3 = tabla[3].c;
        sb.push_back(tabla[3].e);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!ocupado && cyc < 10);
        chk("held_reinicio_flancos", 32'(cyc), 32'd2);
        cyc = 1;
        while (!listo && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("held_latencia2", 32'(cyc), 32'(LAT_NORMAL));
        inicio = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_sin_tercera", 32'(ocupado), 32'd0);

        // Reset at edge 12 aborts the operation asynchronously
        @(negedge clk);
        operando1 = tabla[0].a; operando2 = tabla[0].b; operando3 = tabla[0].c;
        inicio = 1'b1;
        sb.push_back(tabla[0].e);
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("pre_abort_ocupado", 32'(ocupado), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_resultado", 32'(resultado_division), 32'd0);
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk("abort_listo", 32'(listo), 32'd0);
        chk("abort_desborde", 32'(desborde), 32'd0);
        chk("abort_div_cero", 32'(div_cero), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_sin_reanudar", 32'(ocupado), 32'd0);

        // Start on the first edge after reset deasserts
        @(negedge clk);
        reset = 1'b1;
        run_op(tabla[13], -1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_vacio", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
